// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 strip datapath: channel count, frame buffer
// state encoding and the byte-address width helper used by both the buffer and the serializer.
package ws2812_pkg;

  localparam int CHANNELS_PER_LED = 3;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    ACTIVE
  } frame_buffer_state_t;

  function automatic int byte_address_bits(input int n);
    int bytes;
    bytes = n * CHANNELS_PER_LED;
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/ws2812_pixel_bank.sv
// One bank of pixel bytes: synchronous write port and a registered read port.
// Callers only present in-range addresses on an enabled port.
module ws2812_pixel_bank #(
  parameter int DEPTH        = 48,
  parameter int ADDRESS_BITS = 6
) (
  input  logic                    clock_i,
  input  logic                    wr_en_i,
  input  logic [ADDRESS_BITS-1:0] wr_address_i,
  input  logic [7:0]              wr_data_i,
  input  logic                    rd_en_i,
  input  logic [ADDRESS_BITS-1:0] rd_address_i,
  output logic [7:0]              rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clock_i) begin
    if (wr_en_i) mem_q[wr_address_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_address_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ws2812_frame_buffer.sv
// Double-buffered pixel store: the serializer reads the front bank while the host
// fills the back bank; banks exchange only between frames so a refresh never tears.
module ws2812_frame_buffer
  import ws2812_pkg::*;
#(
  parameter int NUMBER_OF_LEDS = 16,
  parameter int ADDRESS_BITS   = byte_address_bits(NUMBER_OF_LEDS)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    pixel_request,
  input  logic [ADDRESS_BITS-1:0] pixel_address,
  output logic                    pixel_ready,
  output logic                    pixel_valid,
  output logic [7:0]              pixel_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDRESS_BITS-1:0] wr_address,
  input  logic [7:0]              wr_data,
  input  logic                    swap_request,
  output logic                    swap_pending,
  output logic                    swap_done
);

  localparam int                      DEPTH     = NUMBER_OF_LEDS * CHANNELS_PER_LED;
  localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(DEPTH - 1);
  localparam logic [ADDRESS_BITS:0]   DEPTH_EXT = (ADDRESS_BITS + 1)'(DEPTH);

  frame_buffer_state_t     state_q, state_d;
  logic [ADDRESS_BITS-1:0] clear_addr_q, clear_addr_d;
  logic                    front_q, front_d;
  logic                    pending_q, pending_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic                    rd_sel_q, rd_sel_d;
  logic                    rd_oor_q, rd_oor_d;

  logic                    clearing, idle_swap, swap_now;
  logic                    rd_accept, wr_accept, rd_in_range, wr_in_range;
  logic [1:0]              bank_wr_en, bank_rd_en;
  logic [ADDRESS_BITS-1:0] bank_wr_addr;
  logic [7:0]              bank_wr_data;
  logic [7:0]              bank_rd_data [2];

  assign clearing    = (state_q == CLEAR);
  assign rd_in_range = ({1'b0, pixel_address} < DEPTH_EXT);
  assign wr_in_range = ({1'b0, wr_address} < DEPTH_EXT);
  assign idle_swap   = (state_q == IDLE) && pending_q;

  // Holding off reads during the idle swap cycle guarantees the new frame starts on the new front bank.
  assign pixel_ready = !clearing && !valid_q && !idle_swap;
  assign wr_ready    = !clearing && !pending_q;
  assign rd_accept   = pixel_request && pixel_ready;
  assign wr_accept   = wr_valid && wr_ready;

  // Leaving ACTIVE on the last byte counts as reaching the frame boundary.
  assign swap_now = idle_swap ||
                    (pending_q && (state_q == ACTIVE) && rd_accept && (pixel_address == LAST_ADDR));

  always_comb begin
    bank_wr_en   = '0;
    bank_rd_en   = '0;
    bank_wr_addr = wr_address;
    bank_wr_data = wr_data;
    if (clearing) begin
      bank_wr_en   = 2'b11;
      bank_wr_addr = clear_addr_q;
      bank_wr_data = '0;
    end else if (wr_accept && wr_in_range) begin
      bank_wr_en[!front_q] = 1'b1;
    end
    if (rd_accept && rd_in_range) bank_rd_en[front_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    front_d      = front_q;
    pending_d    = pending_q;
    done_d       = 1'b0;
    valid_d      = rd_accept;
    rd_sel_d     = rd_sel_q;
    rd_oor_d     = rd_oor_q;
    case (state_q)
      CLEAR: begin
        clear_addr_d = clear_addr_q + 1'b1;
        if (clear_addr_q == LAST_ADDR) begin
          state_d      = IDLE;
          clear_addr_d = '0;
        end
      end
      IDLE:    if (rd_accept && (pixel_address == '0)) state_d = ACTIVE;
      ACTIVE:  if (rd_accept && (pixel_address == LAST_ADDR)) state_d = IDLE;
      default: state_d = CLEAR;
    endcase
    if (rd_accept) begin
      rd_sel_d = front_q;
      rd_oor_d = !rd_in_range;
    end
    if (swap_now) begin
      front_d   = !front_q;
      pending_d = 1'b0;
      done_d    = 1'b1;
    end else if (swap_request && !clearing) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= CLEAR;
      clear_addr_q <= '0;
      front_q      <= 1'b0;
      pending_q    <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      rd_sel_q     <= 1'b0;
      rd_oor_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      front_q      <= front_d;
      pending_q    <= pending_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      rd_sel_q     <= rd_sel_d;
      rd_oor_q     <= rd_oor_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ws2812_pixel_bank #(
      .DEPTH       (DEPTH),
      .ADDRESS_BITS(ADDRESS_BITS)
    ) u_bank (
      .clock_i     (clock),
      .wr_en_i     (bank_wr_en[b]),
      .wr_address_i(bank_wr_addr),
      .wr_data_i   (bank_wr_data),
      .rd_en_i     (bank_rd_en[b]),
      .rd_address_i(pixel_address),
      .rd_data_o   (bank_rd_data[b])
    );
  end

  assign pixel_valid  = valid_q;
  assign pixel_data   = (valid_q && !rd_oor_q) ? bank_rd_data[rd_sel_q] : 8'h00;
  assign swap_pending = pending_q;
  assign swap_done    = done_q;

endmodule
